// File: rtl/relu_maxpool_2x2.sv
// Streaming ReLU + 2x2/stride-2 max-pool on a raster stream of signed pixels.
// One line of horizontal pair maxima is buffered on even rows and consumed on odd rows.
module relu_maxpool_2x2 #(
  parameter int DW    = 24,
  parameter int IMG_W = 64
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          DIN_VALID,
  input  logic [DW-1:0] DIN,
  input  logic          DIN_LAST_IN_LINE,
  input  logic          DIN_LAST_PIX,
  output logic [DW-1:0] OUT,
  output logic          VALID,
  output logic          LAST_IN_LINE,
  output logic          LAST_PIX
);

  localparam int CW   = $clog2(IMG_W);
  localparam int AW   = CW - 1;
  localparam int LB_D = 1 << AW;

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]          col_q, col_d;
  logic                   row_q, row_d;
  logic signed [DW-1:0]   hold_q, hold_d;
  logic [DW-1:0]          out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   lil_q, lil_d;
  logic                   lp_q, lp_d;

  logic signed [DW-1:0]   lb_mem [0:LB_D-1];
  logic [AW-1:0]          lb_idx_s;
  logic                   lb_we_s;
  logic signed [DW-1:0]   lb_rd_s;
  logic signed [DW-1:0]   pair_s;
  logic signed [DW-1:0]   win_s;

  assign lb_idx_s = col_q[CW-1:1];
  assign lb_rd_s  = lb_mem[lb_idx_s];
  assign pair_s   = smax(hold_q, DIN);
  assign win_s    = smax(pair_s, lb_rd_s);

  // Next-state: position tracking, pairing, buffering and window completion.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    out_d   = out_q;
    valid_d = 1'b0;
    lil_d   = 1'b0;
    lp_d    = 1'b0;
    lb_we_s = 1'b0;
    if (DIN_VALID) begin
      if (!col_q[0]) begin
        hold_d = DIN;
      end else if (!row_q) begin
        lb_we_s = 1'b1;
      end else begin
        out_d   = win_s[DW-1] ? {DW{1'b0}} : win_s;
        valid_d = 1'b1;
        lil_d   = DIN_LAST_IN_LINE;
        lp_d    = DIN_LAST_PIX;
      end
      // Markers resync position regardless of the nominal line length.
      if (DIN_LAST_PIX) begin
        col_d = {CW{1'b0}};
        row_d = 1'b0;
      end else if (DIN_LAST_IN_LINE) begin
        col_d = {CW{1'b0}};
        row_d = ~row_q;
      end else if (col_q == CW'(IMG_W - 1)) begin
        col_d = {CW{1'b0}};
      end else begin
        col_d = col_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      col_d = col_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      col_q   <= {CW{1'b0}};
      row_q   <= 1'b0;
      hold_q  <= {DW{1'b0}};
      out_q   <= {DW{1'b0}};
      valid_q <= 1'b0;
      lil_q   <= 1'b0;
      lp_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      lil_q   <= lil_d;
      lp_q    <= lp_d;
    end
  end

  // Line buffer write; contents need no reset since even rows always fill before odd rows read.
  always_ff @(posedge CLK) begin
    if (lb_we_s) begin
      lb_mem[lb_idx_s] <= pair_s;
    end
  end

  assign OUT          = out_q;
  assign VALID        = valid_q;
  assign LAST_IN_LINE = lil_q;
  assign LAST_PIX     = lp_q;

endmodule
